reg_file_sb: RTL and testbench

- Parametrised next-generation register file for the pipelined CPU: two asynchronous read ports and two synchronous write ports.
- Adds an optional hardwired-zero register, optional write-to-read bypass, and a per-register pending scoreboard for hazard detection.
- Sits between decode (reads, issue marking) and writeback/late-result paths (writes).
- Replaces the single-write-port register file in the pipelined core.

---
 rtl/reg_file_sb_pkg.sv | 9 +
 rtl/reg_sb_bits.sv | 79 +++++++
 rtl/reg_file_sb.sv | 112 +++++++++++
 tb/tb_reg_file_sb.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared defaults for the scoreboarded register file: port widths and the
// index of the optional hardwired-zero register.
package reg_file_sb_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int ZERO_IDX       = 0;

endpackage

// File: rtl/reg_sb_bits.sv
// Pending-producer scoreboard: one bit per register with flush > issue > write-clear
// priority, plus the two combinational busy lookups for the read ports.
module reg_sb_bits
    import reg_file_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    input  logic                  flush,
    input  logic                  wen0,
    input  logic [ADDR_WIDTH-1:0] waddr0,
    input  logic                  wen1,
    input  logic [ADDR_WIDTH-1:0] waddr1,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic                  rbusy1,
    output logic                  rbusy2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_A = ADDR_WIDTH'(ZERO_IDX);

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        if (flush) begin
            pending_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // A newly issued producer supersedes whatever is being written now.
                if (issue_valid && (issue_addr == ADDR_WIDTH'(i))) begin
                    pending_d[i] = 1'b1;
                end else if ((wen0 && (waddr0 == ADDR_WIDTH'(i))) ||
                             (wen1 && (waddr1 == ADDR_WIDTH'(i)))) begin
                    pending_d[i] = 1'b0;
                end
            end
        end
        if (ZERO_REG) begin
            pending_d[ZERO_IDX] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    logic hit1;
    logic hit2;

    always_comb begin
        hit1 = (wen0 && (waddr0 == raddr1)) || (wen1 && (waddr1 == raddr1));
        hit2 = (wen0 && (waddr0 == raddr2)) || (wen1 && (waddr1 == raddr2));

        rbusy1 = pending_q[raddr1];
        rbusy2 = pending_q[raddr2];
        // An in-flight write is forwarded, so the reader need not stall on it.
        if (BYPASS && hit1) rbusy1 = 1'b0;
        if (BYPASS && hit2) rbusy2 = 1'b0;
        if (ZERO_REG && (raddr1 == ZERO_A)) rbusy1 = 1'b0;
        if (ZERO_REG && (raddr2 == ZERO_A)) rbusy2 = 1'b0;
        if (rst) begin
            rbusy1 = 1'b0;
            rbusy2 = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read / two-write register file with optional zero register, optional
// write-to-read forwarding and a pending-producer scoreboard.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  rbusy1,
    output logic                  rbusy2,
    input  logic                  wen0,
    input  logic [ADDR_WIDTH-1:0] waddr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  wen1,
    input  logic [ADDR_WIDTH-1:0] waddr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    input  logic                  flush
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_A = ADDR_WIDTH'(ZERO_IDX);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    // Writes aimed at the hardwired zero register are dropped before they reach
    // storage or the forwarding path.
    logic we0;
    logic we1;

    always_comb begin
        we0 = wen0 && !(ZERO_REG && (waddr0 == ZERO_A));
        we1 = wen1 && !(ZERO_REG && (waddr1 == ZERO_A));
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we1) regs_d[waddr1] = wdata1;
        if (we0) regs_d[waddr0] = wdata0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_sel(
        input logic                  in_rst,
        input logic                  is_zero,
        input logic                  hit0,
        input logic                  hit1,
        input logic [DATA_WIDTH-1:0] stored,
        input logic [DATA_WIDTH-1:0] d0,
        input logic [DATA_WIDTH-1:0] d1
    );
        logic [DATA_WIDTH-1:0] v;
        v = stored;
        if (BYPASS && hit1) v = d1;
        if (BYPASS && hit0) v = d0;
        if ((ZERO_REG && is_zero) || in_rst) v = '0;
        return v;
    endfunction

    always_comb begin
        rdata1 = read_sel(rst, raddr1 == ZERO_A,
                          we0 && (waddr0 == raddr1), we1 && (waddr1 == raddr1),
                          regs_q[raddr1], wdata0, wdata1);
        rdata2 = read_sel(rst, raddr2 == ZERO_A,
                          we0 && (waddr0 == raddr2), we1 && (waddr1 == raddr2),
                          regs_q[raddr2], wdata0, wdata1);
    end

    reg_sb_bits #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .flush       (flush),
        .wen0        (wen0),
        .waddr0      (waddr0),
        .wen1        (wen1),
        .waddr1      (waddr1),
        .raddr1      (raddr1),
        .raddr2      (raddr2),
        .rbusy1      (rbusy1),
        .rbusy2      (rbusy2)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: a default build (zero register, forwarding) and an alternate
// build (no zero register, no forwarding) driven by the same stimulus.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  raddr1 = '0, raddr2 = '0;
    logic        wen0 = 1'b0, wen1 = 1'b0;
    logic [4:0]  waddr0 = '0, waddr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic        flush = 1'b0;

    logic [31:0] d_rdata1, d_rdata2, a_rdata1, a_rdata2;
    logic        d_rbusy1, d_rbusy2, a_rbusy1, a_rbusy2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reg_file_sb u_dut (
        .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(d_rdata1), .rdata2(d_rdata2), .rbusy1(d_rbusy1), .rbusy2(d_rbusy2),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .flush(flush)
    );

    reg_file_sb #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_alt (
        .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(a_rdata1), .rdata2(a_rdata2), .rbusy1(a_rbusy1), .rbusy2(a_rbusy2),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .flush(flush)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen0 = 1'b0; wen1 = 1'b0; issue_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        raddr1 = 5'd5;
        #1;
        check("rst_rdata1", d_rdata1, 32'h0);
        check("rst_rbusy1", 32'(d_rbusy1), 32'h0);
        rst = 1'b0;
        tick();

        // r5 written and issued, then reset asserted mid-cycle
        wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        tick();
        idle();
        issue_valid = 1'b1; issue_addr = 5'd5;
        tick();
        idle();
        #1;
        check("r5_written", d_rdata1, 32'hDEADBEEF);
        check("r5_busy", 32'(d_rbusy1), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_rdata", d_rdata1, 32'h0);
        check("rst_async_rbusy", 32'(d_rbusy1), 32'h0);
        check("rst_async_alt_rdata", a_rdata1, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("rst_cleared_r5", d_rdata1, 32'h0);
        check("rst_cleared_busy", 32'(d_rbusy1), 32'h0);

        // both write ports to r7: port 0 wins
        wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        raddr1 = 5'd7;
        #1;
        check("conflict_bypass", d_rdata1, 32'h11);
        check("conflict_nobypass_old", a_rdata1, 32'h0);
        tick();
        idle();
        #1;
        check("conflict_stored", d_rdata1, 32'h11);
        check("conflict_stored_alt", a_rdata1, 32'h11);

        // zero register write and issue
        wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
        issue_valid = 1'b1; issue_addr = 5'd0;
        raddr1 = 5'd0;
        tick();
        idle();
        #1;
        check("zero_rdata", d_rdata1, 32'h0);
        check("zero_rbusy", 32'(d_rbusy1), 32'h0);
        check("nozero_rdata", a_rdata1, 32'hFFFFFFFF);
        check("nozero_rbusy", 32'(a_rbusy1), 32'h1);

        // forwarding on read port 2
        wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5;
        raddr2 = 5'd3;
        #1;
        check("bypass_same_cycle", d_rdata2, 32'hA5);
        check("nobypass_same_cycle", a_rdata2, 32'h0);
        tick();
        idle();
        #1;
        check("nobypass_next_cycle", a_rdata2, 32'hA5);

        // scoreboard on r9
        issue_valid = 1'b1; issue_addr = 5'd9;
        raddr1 = 5'd9;
        tick();
        idle();
        #1;
        check("sb_issue_busy", 32'(d_rbusy1), 32'h1);
        wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99;
        issue_valid = 1'b1; issue_addr = 5'd9;
        #1;
        check("sb_wr_iss_bypass_busy", 32'(d_rbusy1), 32'h0);
        check("sb_wr_iss_alt_busy", 32'(a_rbusy1), 32'h1);
        tick();
        idle();
        #1;
        check("sb_reissue_busy", 32'(d_rbusy1), 32'h1);
        check("sb_reissue_busy_alt", 32'(a_rbusy1), 32'h1);
        wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h77;
        #1;
        check("sb_write_bypass_busy", 32'(d_rbusy1), 32'h0);
        check("sb_write_bypass_data", d_rdata1, 32'h77);
        check("sb_write_alt_busy", 32'(a_rbusy1), 32'h1);
        check("sb_write_alt_data", a_rdata1, 32'h99);
        tick();
        idle();
        #1;
        check("sb_cleared", 32'(d_rbusy1), 32'h0);
        check("sb_cleared_alt", 32'(a_rbusy1), 32'h0);
        check("sb_r9_data", a_rdata1, 32'h77);

        // flush with a simultaneous issue
        issue_valid = 1'b1; issue_addr = 5'd4;
        tick();
        issue_addr = 5'd6;
        tick();
        issue_addr = 5'd8;
        tick();
        idle();
        raddr1 = 5'd4; raddr2 = 5'd8;
        #1;
        check("pre_flush_r4", 32'(d_rbusy1), 32'h1);
        check("pre_flush_r8", 32'(d_rbusy2), 32'h1);
        flush = 1'b1; issue_valid = 1'b1; issue_addr = 5'd10;
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            raddr1 = 5'(4 + 2 * k);
            raddr2 = 5'(4 + 2 * k);
            #1;
            check($sformatf("flush_r%0d", 4 + 2 * k), 32'(d_rbusy1), 32'h0);
            check($sformatf("flush_alt_r%0d", 4 + 2 * k), 32'(a_rbusy2), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
